// File: rtl/oam_dma.sv
// oam_dma: sprite OAM DMA engine.
// A CPU write of the page number to TRIG_ADDR halts the CPU and copies the
// 256 bytes of that page, one read then one write per byte, into the PPU
// sprite-data port at OAM_ADDR.
// Optional feature macro: OAM_DMA_ODD_ALIGN_EN. When defined, a free-running
// parity bit selects an extra ALIGN cycle after HALTC on odd cycles; when
// undefined, ALIGN and the parity bit do not exist and HALTC always goes
// straight to READ.
module oam_dma #(
    parameter logic [15:0] TRIG_ADDR = 16'h4014,
    parameter logic [15:0] OAM_ADDR  = 16'h2004
) (
    input  logic        CLKCPU,
    input  logic        RESET,
    input  logic [15:0] ea,
    input  logic [7:0]  din,
    input  logic        WREQ,
    input  logic [7:0]  mem_din,
    output logic        HALT,
    output logic [15:0] dma_ea,
    output logic [7:0]  dma_dout,
    output logic        dma_rd,
    output logic        dma_we,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALTC = 3'd1,
`ifdef OAM_DMA_ODD_ALIGN_EN
        ST_ALIGN = 3'd2,
`endif
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  index_q, index_d;
    logic [7:0]  data_q, data_d;
    logic        trigger;

    // A trigger is only honoured from IDLE, so re-writes during a transfer
    // (including on the final WRITE edge) leave page and index untouched.
    assign trigger = WREQ && (ea == TRIG_ADDR) && (state_q == ST_IDLE);

`ifdef OAM_DMA_ODD_ALIGN_EN
    logic par_q, par_d;

    // Parity toggles every cycle from reset, independent of transfers.
    always_comb begin
        par_d = ~par_q;
    end

    // Parity register, cleared by reset.
    always_ff @(posedge CLKCPU or posedge RESET) begin
        if (RESET) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    // Next-state logic: sequence HALTC, optional ALIGN, then READ/WRITE pairs.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        index_d = index_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    page_d  = din;
                    index_d = 8'h00;
                    state_d = ST_HALTC;
                end
            end
            ST_HALTC: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
                state_d = par_q ? ST_ALIGN : ST_READ;
`else
                state_d = ST_READ;
`endif
            end
`ifdef OAM_DMA_ODD_ALIGN_EN
            ST_ALIGN: begin
                state_d = ST_READ;
            end
`endif
            ST_READ: begin
                data_d  = mem_din;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                index_d = index_q + 8'h01;
                state_d = (index_q == 8'hFF) ? ST_IDLE : ST_READ;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer at once.
    always_ff @(posedge CLKCPU or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            page_q  <= 8'h00;
            index_q <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            index_q <= index_d;
            data_q  <= data_d;
        end
    end

    // Moore output decode: outputs depend only on registered state/data.
    always_comb begin
        HALT     = 1'b0;
        BUSY     = 1'b0;
        dma_ea   = 16'h0000;
        dma_dout = 8'h00;
        dma_rd   = 1'b0;
        dma_we   = 1'b0;
        if (state_q != ST_IDLE) begin
            HALT = 1'b1;
            BUSY = 1'b1;
        end
        if (state_q == ST_READ) begin
            dma_ea = {page_q, index_q};
            dma_rd = 1'b1;
        end
        if (state_q == ST_WRITE) begin
            dma_ea   = OAM_ADDR;
            dma_dout = data_q;
            dma_we   = 1'b1;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed self-checking bench for oam_dma.
module tb_oam_dma;

    logic        CLKCPU = 1'b0;
    logic        RESET;
    logic [15:0] ea;
    logic [7:0]  din;
    logic        WREQ;
    logic [7:0]  mem_din;
    logic        HALT;
    logic [15:0] dma_ea;
    logic [7:0]  dma_dout;
    logic        dma_rd;
    logic        dma_we;
    logic        BUSY;

    logic [7:0]  mem [0:65535];
    int          checks = 0;
    int          failures = 0;
    logic        tb_par;

`ifdef OAM_DMA_ODD_ALIGN_EN
    localparam int EXP_ODD = 514;
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam int EXP_ODD = 513;
    localparam bit ALIGN_EN = 1'b0;
`endif

    oam_dma dut (
        .CLKCPU   (CLKCPU),
        .RESET    (RESET),
        .ea       (ea),
        .din      (din),
        .WREQ     (WREQ),
        .mem_din  (mem_din),
        .HALT     (HALT),
        .dma_ea   (dma_ea),
        .dma_dout (dma_dout),
        .dma_rd   (dma_rd),
        .dma_we   (dma_we),
        .BUSY     (BUSY)
    );

    // Free-running CPU clock.
    always #5 CLKCPU = ~CLKCPU;

    // CPU-space memory answers in the same cycle as the read address.
    assign mem_din = mem[dma_ea];

    // Reference cycle parity, toggling every cycle from reset.
    always @(posedge CLKCPU or posedge RESET) begin
        if (RESET) tb_par <= 1'b0;
        else       tb_par <= ~tb_par;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive CPU inputs for one cycle, returning at the next falling edge.
    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input logic w);
        ea   = a;
        din  = d;
        WREQ = w;
        @(negedge CLKCPU);
    endtask

    // Drive a trigger so that the HALTC cycle sees the requested parity.
    task automatic startTransfer(input logic [7:0] page, input logic halt_par);
        if (tb_par !== ~halt_par) applyStimulus(16'h0000, 8'h00, 1'b0);
        ea   = 16'h4014;
        din  = page;
        WREQ = 1'b1;
    endtask

    // Follow one transfer cycle by cycle, checking bus order and data.
    task automatic watchTransfer(input logic [7:0] page, input int inject_at,
                                 input bit end_trigger, input int reset_after,
                                 output int busy_cnt, output int rd_cnt,
                                 output int wr_cnt, output int err_cnt,
                                 output logic [15:0] last_rd,
                                 output logic [7:0] first_wr,
                                 output logic [7:0] last_wr,
                                 output logic par_halt);
        bit done;
        done = 1'b0;
        busy_cnt = 0; rd_cnt = 0; wr_cnt = 0; err_cnt = 0;
        last_rd = 16'h0000; first_wr = 8'h00; last_wr = 8'h00; par_halt = 1'b0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge CLKCPU);
            if (!BUSY) begin
                done = 1'b1;
            end else begin
                if (busy_cnt == 0) par_halt = tb_par;
                busy_cnt++;
                if (HALT !== 1'b1) err_cnt++;
                if (dma_rd && dma_we) err_cnt++;
                if (dma_rd) begin
                    if (dma_ea !== {page, rd_cnt[7:0]} || rd_cnt >= 256) err_cnt++;
                    last_rd = dma_ea;
                    rd_cnt++;
                end else if (!dma_we && dma_ea !== 16'h0000) begin
                    err_cnt++;
                end
                if (dma_we) begin
                    if (dma_ea !== 16'h2004 || wr_cnt >= 256 ||
                        dma_dout !== mem[{page, wr_cnt[7:0]}]) err_cnt++;
                    if (wr_cnt == 0) first_wr = dma_dout;
                    last_wr = dma_dout;
                    wr_cnt++;
                end else if (dma_dout !== 8'h00) begin
                    err_cnt++;
                end
                ea   = 16'h0000;
                WREQ = 1'b0;
                if (busy_cnt == inject_at) begin
                    ea = 16'h4014; din = 8'h07; WREQ = 1'b1;
                end
                if (end_trigger && dma_we && wr_cnt == 256) begin
                    ea = 16'h4014; din = page; WREQ = 1'b1;
                end
                if (reset_after > 0 && dma_we && wr_cnt == reset_after) begin
                    RESET = 1'b1;
                    #1;
                    checkOutput("abort_halt", HALT, 1'b0);
                    checkOutput("abort_busy", BUSY, 1'b0);
                    checkOutput("abort_we", dma_we, 1'b0);
                    checkOutput("abort_rd", dma_rd, 1'b0);
                    done = 1'b1;
                end
            end
        end
        checkOutput("transfer_terminated", done, 1'b1);
    endtask

    int          busy_cnt, rd_cnt, wr_cnt, err_cnt, idle_err;
    logic [15:0] last_rd;
    logic [7:0]  first_wr, last_wr;
    logic        par_halt;

    // Directed sequence of reset, triggers, collisions and aborts.
    initial begin
        RESET = 1'b1; ea = 16'h0000; din = 8'h00; WREQ = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'(a * 7 + 3);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

        repeat (3) @(negedge CLKCPU);
        checkOutput("rst_halt", HALT, 1'b0);
        checkOutput("rst_busy", BUSY, 1'b0);
        checkOutput("rst_rd", dma_rd, 1'b0);
        checkOutput("rst_we", dma_we, 1'b0);
        checkOutput("rst_ea", dma_ea, 16'h0000);
        checkOutput("rst_dout", dma_dout, 8'h00);
        RESET = 1'b0;
        applyStimulus(16'h0000, 8'h00, 1'b0);

        applyStimulus(16'h4015, 8'h02, 1'b1);
        applyStimulus(16'h0000, 8'h00, 1'b0);
        checkOutput("wrong_addr_busy", BUSY, 1'b0);
        applyStimulus(16'h4014, 8'h02, 1'b0);
        applyStimulus(16'h0000, 8'h00, 1'b0);
        checkOutput("read_trig_busy", BUSY, 1'b0);

        startTransfer(8'h02, 1'b0);
        watchTransfer(8'h02, -1, 1'b0, -1, busy_cnt, rd_cnt, wr_cnt, err_cnt,
                      last_rd, first_wr, last_wr, par_halt);
        checkOutput("even_busy_cycles", busy_cnt, 513);
        checkOutput("even_reads", rd_cnt, 256);
        checkOutput("even_writes", wr_cnt, 256);
        checkOutput("even_bus_errors", err_cnt, 0);
        checkOutput("even_first_data", first_wr, 8'h5A);
        checkOutput("even_last_data", last_wr, 8'hA5);
        checkOutput("even_last_read", last_rd, 16'h02FF);

        startTransfer(8'h02, 1'b1);
        watchTransfer(8'h02, -1, 1'b0, -1, busy_cnt, rd_cnt, wr_cnt, err_cnt,
                      last_rd, first_wr, last_wr, par_halt);
        checkOutput("odd_busy_cycles", busy_cnt, EXP_ODD);
        checkOutput("odd_writes", wr_cnt, 256);
        checkOutput("odd_bus_errors", err_cnt, 0);
        checkOutput("odd_first_data", first_wr, 8'h5A);
        checkOutput("odd_last_data", last_wr, 8'hA5);

        startTransfer(8'h03, 1'b0);
        watchTransfer(8'h03, 100, 1'b0, -1, busy_cnt, rd_cnt, wr_cnt, err_cnt,
                      last_rd, first_wr, last_wr, par_halt);
        checkOutput("busy_trig_cycles", busy_cnt, 513);
        checkOutput("busy_trig_reads", rd_cnt, 256);
        checkOutput("busy_trig_errors", err_cnt, 0);
        checkOutput("busy_trig_last_read", last_rd, 16'h03FF);

        startTransfer(8'hFF, 1'b0);
        watchTransfer(8'hFF, -1, 1'b1, -1, busy_cnt, rd_cnt, wr_cnt, err_cnt,
                      last_rd, first_wr, last_wr, par_halt);
        checkOutput("ff_busy_cycles", busy_cnt, 513);
        checkOutput("ff_reads", rd_cnt, 256);
        checkOutput("ff_errors", err_cnt, 0);
        checkOutput("ff_last_read", last_rd, 16'hFFFF);
        checkOutput("end_edge_trig_ignored", BUSY, 1'b0);

        watchTransfer(8'hFF, -1, 1'b0, -1, busy_cnt, rd_cnt, wr_cnt, err_cnt,
                      last_rd, first_wr, last_wr, par_halt);
        checkOutput("first_idle_trig_cycles", busy_cnt,
                    513 + ((ALIGN_EN && par_halt) ? 1 : 0));
        checkOutput("first_idle_trig_writes", wr_cnt, 256);
        checkOutput("first_idle_trig_errors", err_cnt, 0);

        startTransfer(8'h04, 1'b0);
        watchTransfer(8'h04, -1, 1'b0, 40, busy_cnt, rd_cnt, wr_cnt, err_cnt,
                      last_rd, first_wr, last_wr, par_halt);
        checkOutput("abort_write_count", wr_cnt, 40);
        checkOutput("abort_errors", err_cnt, 0);
        applyStimulus(16'h0000, 8'h00, 1'b0);
        applyStimulus(16'h0000, 8'h00, 1'b0);
        RESET = 1'b0;
        idle_err = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(16'h0000, 8'h00, 1'b0);
            if (BUSY || HALT || dma_rd || dma_we) idle_err++;
        end
        checkOutput("post_reset_quiet", idle_err, 0);

        startTransfer(8'h02, 1'b0);
        watchTransfer(8'h02, -1, 1'b0, -1, busy_cnt, rd_cnt, wr_cnt, err_cnt,
                      last_rd, first_wr, last_wr, par_halt);
        checkOutput("retrigger_cycles", busy_cnt, 513);
        checkOutput("retrigger_errors", err_cnt, 0);
        checkOutput("retrigger_first_data", first_wr, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
